// File: rtl/cpu_sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data load/store.
// Optional fetch anti-starvation burst limit: define CPU_SRAM_ARBITER_FAIRNESS_EN.
module cpu_sram_arbiter #(
  parameter int CPU_DATA_WIDTH   = 32,
  parameter int DATA_BURST_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_request_valid,
  output logic                      fetch_request_ready,
  input  logic [CPU_DATA_WIDTH-1:0] fetch_address,
  input  logic                      fetch_cancel,
  output logic                      fetch_response_valid,
  output logic [CPU_DATA_WIDTH-1:0] fetch_response_data,
  input  logic                      data_request_valid,
  output logic                      data_request_ready,
  input  logic [3:0]                data_write_strobe,
  input  logic [CPU_DATA_WIDTH-1:0] data_address,
  input  logic [CPU_DATA_WIDTH-1:0] data_write_data,
  output logic                      data_response_valid,
  output logic [CPU_DATA_WIDTH-1:0] data_response_data,
  output logic                      sram_enable,
  output logic [3:0]                sram_write_strobe,
  output logic [CPU_DATA_WIDTH-1:0] sram_address,
  output logic [CPU_DATA_WIDTH-1:0] sram_write_data,
  input  logic [CPU_DATA_WIDTH-1:0] sram_read_data
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_FETCH        = 2'd1,
    S_FETCH_KILLED = 2'd2,
    S_DATA_READ    = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   force_fetch;
  logic   data_xfer;
  logic   fetch_xfer;

  assign data_request_ready  = !reset && !force_fetch;
  assign fetch_request_ready = !reset && (!data_request_valid || force_fetch);
  assign data_xfer           = data_request_valid && data_request_ready;
  assign fetch_xfer          = fetch_request_valid && fetch_request_ready && !data_xfer;

`ifdef CPU_SRAM_ARBITER_FAIRNESS_EN
  localparam int CNT_W = $clog2(DATA_BURST_LIMIT) + 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DATA_BURST_LIMIT);

  logic [CNT_W-1:0] data_burst_count_q, data_burst_count_d;

  assign force_fetch = fetch_request_valid && (data_burst_count_q == BURST_MAX);

  // Counts only data wins that actually made a waiting fetch wait.
  always_comb begin
    data_burst_count_d = data_burst_count_q;
    if (fetch_xfer || !fetch_request_valid) begin
      data_burst_count_d = '0;
    end else if (data_xfer && (data_burst_count_q != BURST_MAX)) begin
      data_burst_count_d = data_burst_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_burst_count_q <= '0;
    end else begin
      data_burst_count_q <= data_burst_count_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    sram_enable       = 1'b0;
    sram_write_strobe = 4'h0;
    sram_address      = '0;
    sram_write_data   = '0;
    if (data_xfer) begin
      sram_enable       = 1'b1;
      sram_write_strobe = data_write_strobe;
      sram_address      = data_address;
      sram_write_data   = data_write_data;
    end else if (fetch_xfer) begin
      sram_enable  = 1'b1;
      sram_address = fetch_address;
    end
  end

  // Remembers who owns the SRAM word arriving next cycle.
  always_comb begin
    state_d = S_IDLE;
    if (data_xfer) begin
      state_d = (data_write_strobe == 4'h0) ? S_DATA_READ : S_IDLE;
    end else if (fetch_xfer) begin
      state_d = fetch_cancel ? S_FETCH_KILLED : S_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating with reset drops any response that lands during a reset cycle.
  assign fetch_response_valid = !reset && (state_q == S_FETCH) && !fetch_cancel;
  assign data_response_valid  = !reset && (state_q == S_DATA_READ);
  assign fetch_response_data  = sram_read_data;
  assign data_response_data   = sram_read_data;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Randomized bench for cpu_sram_arbiter: a behavioural SRAM plus a transaction-level
// reference model (expected grants, pending response owner, reference memory image).
module tb_cpu_sram_arbiter;

  localparam int W     = 32;
  localparam int LIMIT = 4;
`ifdef CPU_SRAM_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         fetch_request_valid, fetch_request_ready, fetch_cancel;
  logic [W-1:0] fetch_address, fetch_response_data;
  logic         fetch_response_valid;
  logic         data_request_valid, data_request_ready;
  logic [3:0]   data_write_strobe;
  logic [W-1:0] data_address, data_write_data, data_response_data;
  logic         data_response_valid;
  logic         sram_enable;
  logic [3:0]   sram_write_strobe;
  logic [W-1:0] sram_address, sram_write_data, sram_read_data;

  always #5 clock = ~clock;

  cpu_sram_arbiter #(.CPU_DATA_WIDTH(W), .DATA_BURST_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .fetch_request_valid(fetch_request_valid), .fetch_request_ready(fetch_request_ready),
    .fetch_address(fetch_address), .fetch_cancel(fetch_cancel),
    .fetch_response_valid(fetch_response_valid), .fetch_response_data(fetch_response_data),
    .data_request_valid(data_request_valid), .data_request_ready(data_request_ready),
    .data_write_strobe(data_write_strobe), .data_address(data_address),
    .data_write_data(data_write_data),
    .data_response_valid(data_response_valid), .data_response_data(data_response_data),
    .sram_enable(sram_enable), .sram_write_strobe(sram_write_strobe),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  // Behavioural 16-word SRAM, 1-cycle read latency, driven only by the DUT's SRAM port.
  logic [W-1:0] sram_mem [16];
  always @(posedge clock) begin
    if (sram_enable) begin
      if (sram_write_strobe == 4'h0) begin
        sram_read_data <= sram_mem[sram_address[5:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_write_strobe[b]) sram_mem[sram_address[5:2]][8*b +: 8] <= sram_write_data[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [W-1:0] ref_mem [16];
  int           pend_kind;   // 0 none, 1 fetch, 2 killed fetch, 3 load
  logic [W-1:0] pend_data;
  int           burst_cnt;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", tag, cycle, obs, exp);
    end
  endtask

  // One clock: apply inputs at negedge, check all outputs, then advance the model at posedge.
  task automatic run_cycle(input logic rst, input logic fv, input logic [W-1:0] fa, input logic fc,
                           input logic dv, input logic [3:0] ds, input logic [W-1:0] da,
                           input logic [W-1:0] dw);
    logic         e_force, e_dr, e_fr, d_x, f_x;
    int           n_kind, n_cnt;
    logic [W-1:0] n_data, word;
    @(negedge clock);
    reset = rst; fetch_request_valid = fv; fetch_address = fa; fetch_cancel = fc;
    data_request_valid = dv; data_write_strobe = ds; data_address = da; data_write_data = dw;
    #1;
    e_force = FAIR && fv && (burst_cnt == LIMIT);
    e_dr    = !rst && !e_force;
    e_fr    = !rst && (!dv || e_force);
    d_x     = dv && e_dr;
    f_x     = fv && e_fr && !d_x;

    check_eq("data_ready",  W'(data_request_ready),  W'(e_dr));
    check_eq("fetch_ready", W'(fetch_request_ready), W'(e_fr));
    check_eq("sram_en",     W'(sram_enable),         W'(d_x || f_x));
    if (d_x) begin
      check_eq("sram_addr_d", sram_address, da);
      check_eq("sram_strb_d", W'(sram_write_strobe), W'(ds));
      if (ds != 4'h0) check_eq("sram_wdata", sram_write_data, dw);
    end else if (f_x) begin
      check_eq("sram_addr_f", sram_address, fa);
      check_eq("sram_strb_f", W'(sram_write_strobe), '0);
    end
    check_eq("fetch_rsp_v", W'(fetch_response_valid), W'(!rst && pend_kind == 1 && !fc));
    check_eq("data_rsp_v",  W'(data_response_valid),  W'(!rst && pend_kind == 3));
    if (!rst && pend_kind == 1 && !fc) check_eq("fetch_rsp_d", fetch_response_data, pend_data);
    if (!rst && pend_kind == 3)        check_eq("data_rsp_d",  data_response_data,  pend_data);

    $display("cyc=%0d rst=%0b fv=%0b fc=%0b dv=%0b ds=%h grant=%s rsp=%0d", cycle, rst, fv, fc, dv, ds,
             d_x ? "data" : (f_x ? "fetch" : "none"), pend_kind);

    n_kind = 0; n_data = pend_data; n_cnt = burst_cnt;
    if (d_x) begin
      if (ds == 4'h0) begin
        n_kind = 3; n_data = ref_mem[da[5:2]];
      end else begin
        word = ref_mem[da[5:2]];
        for (int b = 0; b < 4; b++) if (ds[b]) word[8*b +: 8] = dw[8*b +: 8];
        ref_mem[da[5:2]] = word;
      end
    end else if (f_x) begin
      n_kind = fc ? 2 : 1; n_data = ref_mem[fa[5:2]];
    end
    if (f_x || !fv) n_cnt = 0;
    else if (d_x && burst_cnt < LIMIT) n_cnt = burst_cnt + 1;
    if (rst) begin n_kind = 0; n_cnt = 0; end
    @(posedge clock);
    pend_kind = n_kind; pend_data = n_data; burst_cnt = n_cnt;
    cycle++;
  endtask

  task automatic rand_cycle(input int p_fv, input int p_dv, input int p_rst);
    logic [3:0] ds;
    ds = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    run_cycle($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_fv,
              {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < p_dv, ds, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_read_data = '0;
    pend_kind = 0; pend_data = '0; burst_cnt = 0;
    reset = 1'b1; fetch_request_valid = 1'b0; fetch_address = '0; fetch_cancel = 1'b0;
    data_request_valid = 1'b0; data_write_strobe = 4'h0; data_address = '0; data_write_data = '0;

    run_cycle(1, 1, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);          // reset holds everything off
    run_cycle(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    run_cycle(0, 1, 32'hBFC00000, 0, 0, 4'h0, 32'h0, 32'h0);   // plain fetch
    run_cycle(0, 1, 32'h4, 0, 1, 4'h0, 32'h100, 32'h0);        // contention, load wins
    run_cycle(0, 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);          // fetch granted
    run_cycle(0, 0, 32'h0, 0, 1, 4'hF, 32'h200, 32'hDEADBEEF); // store
    run_cycle(0, 1, 32'h8, 1, 0, 4'h0, 32'h0, 32'h0);          // cancel on accept
    run_cycle(0, 1, 32'hC, 0, 0, 4'h0, 32'h0, 32'h0);
    run_cycle(0, 0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);          // cancel on response
    run_cycle(0, 0, 32'h0, 0, 1, 4'h0, 32'h200, 32'h0);        // load back the store
    run_cycle(0, 0, 32'h0, 0, 1, 4'h0, 32'h10, 32'h0);
    run_cycle(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);          // reset kills due load
    for (int i = 0; i < 12; i++) run_cycle(0, 1, 32'h20, 0, 1, 4'h0, 32'h30, 32'h0);
    for (int i = 0; i < 1500; i++) rand_cycle(60, 60, 3);
    for (int i = 0; i < 500; i++) rand_cycle(95, 95, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
